exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_pkg.sv | 39 +++
 rtl/imm_gen_unit.sv | 31 +++
 rtl/exec_unit.sv | 106 ++++++++++
 tb/tb_exec_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: datapath width, ALU control codes,
// main-decoder class codes and RV32I opcodes.
package exec_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CTRL_W   = 4;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned OPCODE_W = 7;

  // ALU control codes
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;

  // Main-decoder instruction classes
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALUOP_IARITH = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDR   = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 4'b0011;

  // RV32I opcodes
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_gen_unit.sv
// Immediate generator: sign-extends the instruction immediate by format.
module imm_gen_unit
  import exec_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);

  logic sign;
  assign sign = instr[31];

  // Select and sign-extend the immediate field for the decoded opcode
  always_comb begin
    imm = '0;
    unique case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm = {{20{sign}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{sign}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: immediate generation, ALU decode, ALU and result registers.
// Optional macro EXEC_SHIFT_EN builds the shifter; without it the shift
// codes yield zero and no shift logic exists.
module exec_unit #(
  parameter int unsigned XLEN = exec_pkg::XLEN
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            ENA,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [3:0]      alu_op,
  input  logic            alu_src,
  input  logic [1:0]      auipc_lui,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q,
  output logic [XLEN-1:0] target_q
);

  import exec_pkg::*;

  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] target;

  assign funct3 = instr[14:12];

  imm_gen_unit u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

  // ALU control decode from instruction class and funct fields
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_RTYPE:  alu_ctrl = {instr[30], funct3};
      ALUOP_IARITH: alu_ctrl = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
      ALUOP_ADDR:   alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: begin
        unique case (funct3[2:1])
          2'b00:   alu_ctrl = ALU_SUB;
          2'b10:   alu_ctrl = ALU_SLT;
          2'b11:   alu_ctrl = ALU_SLTU;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default:      alu_ctrl = ALU_ADD;
    endcase
  end

  // Operand muxes: A from pc / zero / rs1, B from rs2 / immediate
  always_comb begin
    op_a = rs1_data;
    unique case (auipc_lui)
      2'b00:   op_a = pc;
      2'b01:   op_a = '0;
      default: op_a = rs1_data;
    endcase
    op_b = alu_src ? imm : rs2_data;
  end

  // ALU datapath; undefined control codes fall back to ADD
  always_comb begin
    result = op_a + op_b;
    unique case (alu_ctrl)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLT:  result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: result = XLEN'(op_a < op_b);
      ALU_XOR:  result = op_a ^ op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
`ifdef EXEC_SHIFT_EN
      ALU_SLL:  result = op_a << op_b[4:0];
      ALU_SRL:  result = op_a >> op_b[4:0];
      ALU_SRA:  result = XLEN'($signed(op_a) >>> op_b[4:0]);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: result = '0;
`endif
      default:  result = op_a + op_b;
    endcase
  end

  assign target = pc + imm;

  // Output registers: load on ENA, cleared asynchronously by reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      target_q <= '0;
    end else if (ENA) begin
      result_q <= result;
      zero_q   <= (result == '0);
      target_q <= target;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit.
module tb_exec_unit;

  logic        CLK;
  logic        RESET_N;
  logic        ENA;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [1:0]  auipc_lui;
  logic [31:0] imm;
  logic [3:0]  alu_ctrl;
  logic [31:0] result_q;
  logic        zero_q;
  logic [31:0] target_q;

  int checks = 0;
  int errors = 0;

  exec_unit #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .ENA       (ENA),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_op    (alu_op),
    .alu_src   (alu_src),
    .auipc_lui (auipc_lui),
    .imm       (imm),
    .alu_ctrl  (alu_ctrl),
    .result_q  (result_q),
    .zero_q    (zero_q),
    .target_q  (target_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic src, input logic [1:0] sel);
    instr = i; pc = p; rs1_data = a; rs2_data = b;
    alu_op = op; alu_src = src; auipc_lui = sel;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] sra_exp;

  initial begin
`ifdef EXEC_SHIFT_EN
    sra_exp = 32'hF800_0000;
`else
    sra_exp = 32'h0000_0000;
`endif
    RESET_N = 1'b0;
    ENA     = 1'b1;
    // add x1,x2,x3 staged during reset
    drive(32'h003100B3, 32'h40, 32'd5, 32'd7, 4'b0000, 1'b0, 2'b10);
    #3;
    chk("reset_result", result_q, 32'h0);
    chk("reset_zero",   {31'b0, zero_q}, 32'h0);
    chk("reset_target", target_q, 32'h0);
    #5 RESET_N = 1'b1;               // t=8, between edges
    chk("add_ctrl", {28'b0, alu_ctrl}, 32'h0);
    chk("add_imm",  imm, 32'h0);
    tick();                          // first edge with reset released
    chk("add_result", result_q, 32'd12);
    chk("add_zero",   {31'b0, zero_q}, 32'h0);
    chk("add_target", target_q, 32'h40);

    // sub with equal operands
    drive(32'h403100B3, 32'h40, 32'h1234, 32'h1234, 4'b0000, 1'b0, 2'b10);
    #1 chk("sub_ctrl", {28'b0, alu_ctrl}, 32'h8);
    tick();
    chk("sub_result", result_q, 32'h0);
    chk("sub_zero",   {31'b0, zero_q}, 32'h1);

    // sra
    drive(32'h403150B3, 32'h40, 32'h8000_0000, 32'd4, 4'b0000, 1'b0, 2'b10);
    #1 chk("sra_ctrl", {28'b0, alu_ctrl}, 32'hD);
    tick();
    chk("sra_result", result_q, sra_exp);
    chk("sra_zero",   {31'b0, zero_q}, {31'b0, sra_exp == 32'h0});

    // addi with imm bit 30 set must still decode to ADD
    drive(32'h40010093, 32'h40, 32'h10, 32'h0, 4'b0001, 1'b1, 2'b10);
    #1 chk("addi_ctrl", {28'b0, alu_ctrl}, 32'h0);
    chk("addi_imm", imm, 32'h400);
    tick();
    chk("addi_result", result_q, 32'h410);
    chk("addi_target", target_q, 32'h440);

    // lui
    drive(32'h12345037, 32'h40, 32'hDEAD_BEEF, 32'h0, 4'b0010, 1'b1, 2'b01);
    #1 chk("lui_imm", imm, 32'h1234_5000);
    tick();
    chk("lui_result", result_q, 32'h1234_5000);
    chk("lui_target", target_q, 32'h1234_5040);

    // auipc
    drive(32'h00001017, 32'h100, 32'h0, 32'h0, 4'b0010, 1'b1, 2'b00);
    tick();
    chk("auipc_result", result_q, 32'h1100);

    // beq -8
    drive(32'hFE310CE3, 32'h100, 32'd9, 32'd9, 4'b0011, 1'b0, 2'b10);
    #1 chk("beq_imm", imm, 32'hFFFF_FFF8);
    chk("beq_ctrl", {28'b0, alu_ctrl}, 32'h8);
    tick();
    chk("beq_target", target_q, 32'hF8);
    chk("beq_zero",   {31'b0, zero_q}, 32'h1);

    // blt: -1 < 1 signed
    drive(32'hFE314CE3, 32'h100, 32'hFFFF_FFFF, 32'd1, 4'b0011, 1'b0, 2'b10);
    #1 chk("blt_ctrl", {28'b0, alu_ctrl}, 32'h2);
    tick();
    chk("blt_result", result_q, 32'h1);

    // bltu: 0xFFFFFFFF < 1 unsigned is false
    drive(32'hFE316CE3, 32'h100, 32'hFFFF_FFFF, 32'd1, 4'b0011, 1'b0, 2'b10);
    #1 chk("bltu_ctrl", {28'b0, alu_ctrl}, 32'h3);
    tick();
    chk("bltu_result", result_q, 32'h0);
    chk("bltu_zero",   {31'b0, zero_q}, 32'h1);

    // branch funct3 01x decodes to ADD
    drive(32'hFE312CE3, 32'h100, 32'd3, 32'd4, 4'b0011, 1'b0, 2'b10);
    #1 chk("br01x_ctrl", {28'b0, alu_ctrl}, 32'h0);

    // remaining immediate formats
    drive(32'hFE20AE23, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 2'b10);
    #1 chk("s_imm", imm, 32'hFFFF_FFFC);
    drive(32'h0080006F, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 2'b10);
    #1 chk("j_imm", imm, 32'h8);
    drive(32'hFFFFFF7F, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 2'b10);
    #1 chk("bad_opc_imm", imm, 32'h0);

    // or / and / xor via R-type
    drive(32'h003160B3, 32'h0, 32'hF0F0_0000, 32'h0000_0F0F, 4'b0000, 1'b0, 2'b10);
    tick();
    chk("or_result", result_q, 32'hF0F0_0F0F);
    drive(32'h003170B3, 32'h0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0000, 1'b0, 2'b10);
    tick();
    chk("and_result", result_q, 32'h0F00_0F00);
    drive(32'h003140B3, 32'h0, 32'hFFFF_0000, 32'hFF00_FF00, 4'b0000, 1'b0, 2'b10);
    tick();
    chk("xor_result", result_q, 32'h00FF_FF00);

    // hold with ENA low
    ENA = 1'b0;
    drive(32'h003100B3, 32'h200, 32'd1, 32'd1, 4'b0000, 1'b0, 2'b10);
    tick();
    chk("hold_result", result_q, 32'h00FF_FF00);
    chk("hold_target", target_q, 32'h0);

    // load nonzero state, then reset between edges
    ENA = 1'b1;
    tick();
    chk("pre_rst_result", result_q, 32'd2);
    chk("pre_rst_target", target_q, 32'h200);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_result", result_q, 32'h0);
    chk("midrst_zero",   {31'b0, zero_q}, 32'h0);
    chk("midrst_target", target_q, 32'h0);
    #1 RESET_N = 1'b1;
    ENA = 1'b0;
    tick();
    chk("post_rst_hold_result", result_q, 32'h0);
    chk("post_rst_hold_target", target_q, 32'h0);
    chk("post_rst_hold_zero",   {31'b0, zero_q}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
